// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared constants and elaboration helpers for the pipelined Wallace multiplier
package mul_pkg;

    // Register stages between operand capture and result_out
    localparam int MUL_LATENCY = 3;

    // Product width for a given operand width
    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

    // Rows entering the tree: WIDTH partial products plus the Baugh-Wooley constant row
    function automatic int pp_rows(input int w);
        return w + 1;
    endfunction

    // Row count after a number of 3:2 compression levels
    function automatic int csa_rows_after(input int n, input int levels);
        int r;
        r = n;
        for (int s = 0; s < levels; s++) begin
            r = (r / 3) * 2 + (r % 3);
        end
        return r;
    endfunction

    // Number of 3:2 levels needed to reduce the tree to two rows
    function automatic int wallace_stages(input int w);
        int r;
        int s;
        r = pp_rows(w);
        s = 0;
        for (int k = 0; k < 64; k++) begin
            if (r > 2) begin
                r = (r / 3) * 2 + (r % 3);
                s = s + 1;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/wallace_csa_tree.sv
// rtl/wallace_csa_tree.sv - combinational Baugh-Wooley / AND-array partial products reduced to two rows
//
// Ports:
//   x, y        WIDTH-bit operands
//   is_signed   1: two's-complement operands (Baugh-Wooley), 0: unsigned AND array
//   sum_row     2*WIDTH-bit sum row of the reduced tree
//   carry_row   2*WIDTH-bit carry row; sum_row + carry_row (mod 2^(2*WIDTH)) is the product
module wallace_csa_tree
    import mul_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               is_signed,
    output logic [2*WIDTH-1:0] sum_row,
    output logic [2*WIDTH-1:0] carry_row
);

    localparam int PW  = prod_width(WIDTH);
    localparam int NR  = pp_rows(WIDTH);
    localparam int NST = wallace_stages(WIDTH);

    // Baugh-Wooley correction: +1 at bit WIDTH and at bit 2*WIDTH-1
    localparam logic [PW-1:0] BW_CONST = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

    // rows[s][r]: row r entering compression level s; rows past the live count are zero
    logic [PW-1:0] rows [0:NST][0:NR-1];

    genvar i, j, s, g, k;

    // Level 0: partial-product rows, each pre-shifted to its weight
    for (i = 0; i < WIDTH; i++) begin : g_pp
        logic [WIDTH-1:0] bits;
        for (j = 0; j < WIDTH; j++) begin : g_bit
            // Exactly one index on the sign column: complemented in signed mode.
            // The corner term pp[W-1][W-1] keeps its true polarity.
            if ((i == WIDTH - 1) != (j == WIDTH - 1)) begin : g_inv
                assign bits[j] = (x[j] & y[i]) ^ is_signed;
            end else begin : g_plain
                assign bits[j] = x[j] & y[i];
            end
        end
        assign rows[0][i] = {{WIDTH{1'b0}}, bits} << i;
    end

    assign rows[0][WIDTH] = {PW{is_signed}} & BW_CONST;

    // Each level takes rows in groups of three through full-adder columns;
    // leftover rows pass through unchanged to the next level.
    for (s = 0; s < NST; s++) begin : g_level
        localparam int N_IN  = csa_rows_after(NR, s);
        localparam int N_FA  = N_IN / 3;
        localparam int N_REM = N_IN % 3;
        localparam int N_OUT = 2 * N_FA + N_REM;

        for (g = 0; g < N_FA; g++) begin : g_fa
            logic [PW-1:0] a;
            logic [PW-1:0] b;
            logic [PW-1:0] c;
            assign a = rows[s][3*g];
            assign b = rows[s][3*g+1];
            assign c = rows[s][3*g+2];
            assign rows[s+1][2*g]   = a ^ b ^ c;
            // Carry out of the top column is dropped: arithmetic is mod 2^PW
            assign rows[s+1][2*g+1] = ((a & b) | (a & c) | (b & c)) << 1;
        end

        for (k = 0; k < N_REM; k++) begin : g_pass
            assign rows[s+1][2*N_FA+k] = rows[s][3*N_FA+k];
        end

        for (k = N_OUT; k < NR; k++) begin : g_zero
            assign rows[s+1][k] = '0;
        end
    end

    assign sum_row   = rows[NST][0];
    assign carry_row = rows[NST][1];

endmodule

// File: rtl/wallace_mul_pipe.sv
// rtl/wallace_mul_pipe.sv - three-stage pipelined Wallace multiplier with valid/ready handshake
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   in_valid       operand pair presented
//   in_ready       operands accepted this cycle (pipe advances)
//   in_signed      1: two's-complement pair, 0: unsigned pair
//   x_in, y_in     WIDTH-bit operands
//   out_valid      product available on result_out
//   out_ready      consumer takes the product this cycle
//   result_out     2*WIDTH-bit product
//   done_cnt       CNT_W-bit count of delivered products, wraps
module wallace_mul_pipe
    import mul_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     x_in,
    input  logic [WIDTH-1:0]     y_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result_out,
    output logic [CNT_W-1:0]     done_cnt
);

    localparam int PW = prod_width(WIDTH);

    // S1: captured operands and mode
    logic             s1_valid;
    logic [WIDTH-1:0] s1_x;
    logic [WIDTH-1:0] s1_y;
    logic             s1_signed;

    // S2: reduced sum/carry rows
    logic             s2_valid;
    logic [PW-1:0]    s2_sum;
    logic [PW-1:0]    s2_carry;

    logic [PW-1:0]    tree_sum;
    logic [PW-1:0]    tree_carry;

    logic             adv;

    // The whole pipe moves as one: a stalled output freezes every stage,
    // so bubbles are kept in place rather than squeezed out.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    wallace_csa_tree #(
        .WIDTH(WIDTH)
    ) u_tree (
        .x         (s1_x),
        .y         (s1_y),
        .is_signed (s1_signed),
        .sum_row   (tree_sum),
        .carry_row (tree_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_x      <= '0;
            s1_y      <= '0;
            s1_signed <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            // Data registers only load on a real pair to avoid toggling on bubbles
            if (in_valid) begin
                s1_x      <= x_in;
                s1_y      <= y_in;
                s1_signed <= in_signed;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_carry <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum   <= tree_sum;
                s2_carry <= tree_carry;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            result_out <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            // Final carry-propagate add; the carry beyond the product width is discarded
            if (s2_valid) begin
                result_out <= s2_sum + s2_carry;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (out_valid && out_ready) begin
            done_cnt <= done_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// tb/tb_wallace_mul_pipe.sv - scoreboard bench for wallace_mul_pipe (WIDTH=12, CNT_W=4)
module tb_wallace_mul_pipe;

    localparam int W  = 12;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_signed;
    logic [W-1:0]  x_in;
    logic [W-1:0]  y_in;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] result_out;
    logic [CW-1:0] done_cnt;

    wallace_mul_pipe #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_signed  (in_signed),
        .x_in       (x_in),
        .y_in       (y_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result_out (result_out),
        .done_cnt   (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   x;
        logic [W-1:0]   y;
        logic           s;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t           tbl [12];
    logic [2*W-1:0] sb_q [$];
    logic [2*W-1:0] pend_exp;
    logic           acc;
    int             n_checks;
    int             n_fail;
    int             deliveries;
    int             cyc;
    int             out_first;
    int             out_last;

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        logic [2*W-1:0]        ua;
        logic [2*W-1:0]        ub;
        if (s) begin
            sa = {{W{a[W-1]}}, a};
            sb = {{W{b[W-1]}}, b};
            return sa * sb;
        end
        ua = {{W{1'b0}}, a};
        ub = {{W{1'b0}}, b};
        return ua * ub;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: log transfers that happen at the coming edge, then move to the next negedge
    task automatic step();
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", 32'(result_out), 32'hDEAD_BEEF);
            end else begin
                chk("product", 32'(result_out), 32'(sb_q.pop_front()));
            end
            deliveries++;
            if (out_first < 0) out_first = cyc;
            out_last = cyc;
        end
        if (acc) sb_q.push_back(pend_exp);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [2*W-1:0] e);
        in_valid  = 1'b1;
        x_in      = a;
        y_in      = b;
        in_signed = s;
        pend_exp  = e;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [2*W-1:0] e);
        int tries;
        offer(a, b, s, e);
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 50) begin
            step();
            tries++;
        end
        if (!acc) chk("send_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n = 0;
        while (sb_q.size() > 0 && n < 40) begin
            step();
            n++;
        end
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog expired");
    end

    logic [W-1:0]   px [4];
    logic [W-1:0]   py [4];
    logic           ps [4];
    logic [2*W-1:0] held;
    logic           stable;
    logic           seen_valid;
    logic           have_pair;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic           rs;
    int             idx;
    int             sent;

    initial begin
        tbl[0]  = '{12'hFFF, 12'hFFF, 1'b0, 24'hFFE001};
        tbl[1]  = '{12'h800, 12'h800, 1'b1, 24'h400000};
        tbl[2]  = '{12'hFFF, 12'h001, 1'b1, 24'hFFFFFF};
        tbl[3]  = '{12'h7FF, 12'h800, 1'b1, 24'hC00800};
        tbl[4]  = '{12'h000, 12'h000, 1'b0, 24'h000000};
        tbl[5]  = '{12'hFFF, 12'h001, 1'b0, 24'h000FFF};
        tbl[6]  = '{12'h7FF, 12'h7FF, 1'b1, 24'h3FF001};
        tbl[7]  = '{12'h800, 12'hFFF, 1'b1, 24'h000800};
        tbl[8]  = '{12'h123, 12'h456, 1'b0, 24'h04EDC2};
        tbl[9]  = '{12'h800, 12'h7FF, 1'b0, 24'h3FF800};
        tbl[10] = '{12'hFFF, 12'hFFF, 1'b1, 24'h000001};
        tbl[11] = '{12'h000, 12'h800, 1'b1, 24'h000000};

        n_checks   = 0;
        n_fail     = 0;
        deliveries = 0;
        cyc        = 0;
        out_first  = -1;
        out_last   = -1;
        acc        = 1'b0;
        pend_exp   = '0;
        in_valid   = 1'b0;
        in_signed  = 1'b0;
        x_in       = '0;
        y_in       = '0;
        out_ready  = 1'b1;
        rst_n      = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result_out), 32'd0);
        chk("rst_done_cnt", 32'(done_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Single product latency: visible after the third edge counting the capture edge
        send(tbl[0].x, tbl[0].y, tbl[0].s, tbl[0].exp);
        in_valid = 1'b0;
        chk("lat_edge1_valid", 32'(out_valid), 32'd0);
        step();
        chk("lat_edge2_valid", 32'(out_valid), 32'd0);
        step();
        chk("lat_edge3_valid", 32'(out_valid), 32'd1);
        chk("lat_edge3_result", 32'(result_out), 32'hFFE001);
        step();
        chk("lat_done_cnt", 32'(done_cnt), 32'd1);
        chk("lat_out_valid_clear", 32'(out_valid), 32'd0);

        // Table vectors streamed back to back
        for (int t = 0; t < 12; t++) send(tbl[t].x, tbl[t].y, tbl[t].s, tbl[t].exp);
        drain();
        chk("table_done_cnt", 32'(done_cnt), 32'(deliveries % 16));

        // Eight random mixed-mode pairs must leave on eight consecutive cycles
        out_first = -1;
        sent = deliveries;
        for (int t = 0; t < 8; t++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            send(ra, rb, rs, model(ra, rb, rs));
        end
        drain();
        chk("stream_count", 32'(deliveries - sent), 32'd8);
        chk("stream_back_to_back", 32'(out_last - out_first), 32'd7);

        // Back-pressure: out_ready low for 5 cycles with 4 pairs offered
        for (int t = 0; t < 4; t++) begin
            px[t] = W'($urandom);
            py[t] = W'($urandom);
            ps[t] = 1'(t & 1);
        end
        sent = deliveries;
        out_ready = 1'b0;
        idx = 0;
        stable = 1'b1;
        seen_valid = 1'b0;
        held = '0;
        for (int c = 0; c < 5; c++) begin
            offer(px[idx], py[idx], ps[idx], model(px[idx], py[idx], ps[idx]));
            step();
            if (acc) idx++;
            if (out_valid) begin
                if (!seen_valid) held = result_out;
                else if (result_out !== held) stable = 1'b0;
                seen_valid = 1'b1;
            end
        end
        chk("stall_accepted", 32'(idx), 32'd3);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_result_stable", 32'(stable), 32'd1);
        chk("stall_held_first", 32'(held), 32'(model(px[0], py[0], ps[0])));
        chk("stall_done_cnt", 32'(done_cnt), 32'(deliveries % 16));
        out_ready = 1'b1;
        while (idx < 4) begin
            send(px[idx], py[idx], ps[idx], model(px[idx], py[idx], ps[idx]));
            idx++;
        end
        drain();
        chk("stall_delivered", 32'(deliveries - sent), 32'd4);

        // Reset with two products in flight
        send(12'h0AB, 12'h0CD, 1'b0, model(12'h0AB, 12'h0CD, 1'b0));
        send(12'h800, 12'h001, 1'b1, model(12'h800, 12'h001, 1'b1));
        in_valid = 1'b0;
        step();
        chk("inflight_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_done_cnt", 32'(done_cnt), 32'd0);
        chk("midrst_result", 32'(result_out), 32'd0);
        sb_q.delete();
        deliveries = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (out_valid) seen_valid = 1'b1;
        end
        chk("post_rst_no_output", 32'(seen_valid), 32'd0);

        // Counter wrap: 17 deliveries into a 4-bit counter
        for (int t = 0; t < 17; t++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            send(ra, rb, rs, model(ra, rb, rs));
        end
        drain();
        chk("wrap_done_cnt", 32'(done_cnt), 32'd1);

        // Random soak with random producer gaps and consumer back-pressure
        sent = 0;
        have_pair = 1'b0;
        while (sent < 10000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!have_pair) begin
                if ($urandom_range(0, 3) != 0) begin
                    ra = W'($urandom);
                    rb = W'($urandom);
                    rs = 1'($urandom);
                    offer(ra, rb, rs, model(ra, rb, rs));
                    have_pair = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            step();
            if (acc) begin
                have_pair = 1'b0;
                in_valid = 1'b0;
                sent++;
            end
        end
        out_ready = 1'b1;
        drain();
        chk("soak_done_cnt", 32'(done_cnt), 32'(deliveries % 16));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
